// File: rtl/axi_controller_core.sv
// Single-outstanding bridge from a simple core memory request port to an
// AXI4 master port. Each request becomes exactly one single-beat AXI
// transaction, and `ready` reports completion back to the requester.
//
// Request side : read, write[1:0] (00 none/01 byte/10 half/11 word), addr,
//                store (right-aligned), done -> ready, load
// AXI side     : AW/W/B write channels and AR/R read channels, master
//                direction, fixed single-beat INCR transfers
// clk / nrst   : clock and asynchronous active-low reset
module axi_controller_core #(
  parameter int unsigned ID_W   = 4,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  nrst,
  // request side
  input  logic                  read,
  input  logic [1:0]            write,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W-1:0]     store,
  input  logic                  done,
  output logic                  ready,
  output logic [DATA_W-1:0]     load,
  // AXI write address
  output logic [ID_W-1:0]       awid,
  output logic [ADDR_W-1:0]     awaddr,
  output logic [7:0]            awlen,
  output logic [2:0]            awsize,
  output logic [1:0]            awburst,
  output logic [0:0]            awlock,
  output logic [3:0]            awcache,
  output logic [2:0]            awprot,
  output logic [3:0]            awqos,
  output logic                  awvalid,
  input  logic                  awready,
  // AXI write data
  output logic [DATA_W-1:0]     wdata,
  output logic [DATA_W/8-1:0]   wstrb,
  output logic                  wlast,
  output logic                  wvalid,
  input  logic                  wready,
  // AXI write response
  input  logic [ID_W-1:0]       bid,
  input  logic [1:0]            bresp,
  input  logic                  bvalid,
  output logic                  bready,
  // AXI read address
  output logic [ID_W-1:0]       arid,
  output logic [ADDR_W-1:0]     araddr,
  output logic [7:0]            arlen,
  output logic [2:0]            arsize,
  output logic [1:0]            arburst,
  output logic [0:0]            arlock,
  output logic [3:0]            arcache,
  output logic [2:0]            arprot,
  output logic [3:0]            arqos,
  output logic                  arvalid,
  input  logic                  arready,
  // AXI read data
  input  logic [ID_W-1:0]       rid,
  input  logic [DATA_W-1:0]     rdata,
  input  logic [1:0]            rresp,
  input  logic                  rlast,
  input  logic                  rvalid,
  output logic                  rready
);

  localparam int unsigned STRB_W = DATA_W / 8;

  typedef enum logic [2:0] {
    S_IDLE, S_WR, S_WR_RESP, S_RD_ADDR, S_RD_DATA, S_COMPLETE
  } state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [STRB_W-1:0]   wstrb_q;
  logic [DATA_W-1:0]   load_q;
  logic                awvalid_q, wvalid_q, arvalid_q, bready_q, rready_q;

  logic [STRB_W-1:0]   lane_strb;
  logic [DATA_W-1:0]   lane_data;
  logic                aw_done_c, w_done_c;

  // Place right-aligned store data onto the byte lanes selected by addr[1:0]
  always_comb begin
    lane_strb = '1;
    lane_data = store;
    case (write)
      2'b01: begin
        lane_strb = STRB_W'(4'b0001 << addr[1:0]);
        lane_data = DATA_W'(store << {addr[1:0], 3'b000});
      end
      2'b10: begin
        lane_strb = STRB_W'(4'b0011 << addr[1:0]);
        lane_data = DATA_W'(store << {addr[1:0], 3'b000});
      end
      default: ;
    endcase
  end

  // A channel counts as finished once its valid has dropped or is being accepted now
  assign aw_done_c = !awvalid_q || awready;
  assign w_done_c  = !wvalid_q  || wready;

  // Transaction sequencer; request fields are latched only when leaving IDLE
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      load_q    <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      bready_q  <= 1'b0;
      rready_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (read) begin
            addr_q    <= {addr[ADDR_W-1:2], 2'b00};
            arvalid_q <= 1'b1;
            state_q   <= S_RD_ADDR;
          end else if (write != 2'b00) begin
            addr_q    <= {addr[ADDR_W-1:2], 2'b00};
            wdata_q   <= lane_data;
            wstrb_q   <= lane_strb;
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
            state_q   <= S_WR;
          end
        end
        S_WR: begin
          if (awready) awvalid_q <= 1'b0;
          if (wready)  wvalid_q  <= 1'b0;
          if (aw_done_c && w_done_c) begin
            bready_q <= 1'b1;
            state_q  <= S_WR_RESP;
          end
        end
        S_WR_RESP: begin
          if (bvalid) begin
            bready_q <= 1'b0;
            state_q  <= S_COMPLETE;
          end
        end
        S_RD_ADDR: begin
          if (arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= S_RD_DATA;
          end
        end
        S_RD_DATA: begin
          if (rvalid) begin
            rready_q <= 1'b0;
            load_q   <= rdata;
            state_q  <= S_COMPLETE;
          end
        end
        S_COMPLETE: begin
          if (done || (!read && write == 2'b00)) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ready   = (state_q == S_COMPLETE);
  assign load    = load_q;

  assign awid    = '0;
  assign awaddr  = addr_q;
  assign awlen   = 8'd0;
  assign awsize  = 3'b010;
  assign awburst = 2'b01;
  assign awlock  = 1'b0;
  assign awcache = 4'b0011;
  assign awprot  = 3'b000;
  assign awqos   = 4'b0000;
  assign awvalid = awvalid_q;

  assign wdata   = wdata_q;
  assign wstrb   = wstrb_q;
  assign wlast   = 1'b1;
  assign wvalid  = wvalid_q;
  assign bready  = bready_q;

  assign arid    = '0;
  assign araddr  = addr_q;
  assign arlen   = 8'd0;
  assign arsize  = 3'b010;
  assign arburst = 2'b01;
  assign arlock  = 1'b0;
  assign arcache = 4'b0011;
  assign arprot  = 3'b000;
  assign arqos   = 4'b0000;
  assign arvalid = arvalid_q;
  assign rready  = rready_q;

  // Response status and IDs are deliberately not inspected
  logic unused_resp;
  assign unused_resp = ^{bid, bresp, rid, rresp, rlast};

endmodule

// File: tb/tb_axi_controller_core.sv
// Randomized bench for axi_controller_core: the bench plays the requester and
// an AXI slave with programmable ready/response delays, and compares against a
// byte-addressed memory model and request-level latency arithmetic.
module tb_axi_controller_core;

  logic        clk = 1'b0;
  logic        nrst;
  logic        read;
  logic [1:0]  write;
  logic [31:0] addr, store;
  logic        done;
  logic        ready;
  logic [31:0] load;
  logic [3:0]  awid, arid;
  logic [31:0] awaddr, araddr;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst;
  logic        awlock, arlock;
  logic [3:0]  awcache, arcache;
  logic [2:0]  awprot, arprot;
  logic [3:0]  awqos, arqos;
  logic        awvalid, awready, arvalid, arready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast, wvalid, wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid, bready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [7:0]  mb   [0:255];   // reference: byte-addressed memory
  logic [31:0] smem [0:63];    // slave storage, written via strobes
  logic [31:0] last_load;

  axi_controller_core dut (
    .clk(clk), .nrst(nrst),
    .read(read), .write(write), .addr(addr), .store(store), .done(done),
    .ready(ready), .load(load),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awlock(awlock), .awcache(awcache), .awprot(awprot),
    .awqos(awqos), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
    .arqos(arqos), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
    .rready(rready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // id/len/size/burst/lock/cache/prot/qos packed for one comparison
  localparam logic [28:0] AXI_CONST = {4'h0, 8'h00, 3'b010, 2'b01, 1'b0, 4'b0011, 3'b000, 4'h0};

  task automatic do_write(input logic [1:0] sz, input logic [7:0] a, input logic [31:0] st,
                          input int aw_dly, input int w_dly, input int b_dly);
    logic [3:0]  e_strb, cap_strb;
    logic [31:0] e_data, e_addr, cap_addr, cap_data;
    logic        aw_hs, w_hs, b_hs;
    int          aw_cnt, w_cnt, b_cnt, cyc, mx;
    e_addr = {24'h0, a[7:2], 2'b00};
    case (sz)
      2'b01: begin
        e_strb = 4'b0001 << a[1:0];
        e_data = st << (8 * a[1:0]);
        mb[a] = st[7:0];
      end
      2'b10: begin
        e_strb = 4'b0011 << a[1:0];
        e_data = st << (8 * a[1:0]);
        mb[a] = st[7:0];
        mb[a + 8'd1] = st[15:8];
      end
      default: begin
        e_strb = 4'b1111;
        e_data = st;
        for (int i = 0; i < 4; i++) mb[a + 8'(i)] = st[8*i +: 8];
      end
    endcase
    mx = (aw_dly > w_dly) ? aw_dly : w_dly;
    aw_hs = 0; w_hs = 0; b_hs = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0; cyc = 0;
    cap_addr = 0; cap_data = 0; cap_strb = 0;
    @(negedge clk);
    read = 0; write = sz; addr = {24'h0, a}; store = st; done = 0;
    while (1) begin
      @(negedge clk);
      cyc++;
      awready = 0; wready = 0; bvalid = 0;
      if (cyc == 1) begin
        addr = $urandom; store = $urandom; write = 2'($urandom_range(1, 3));
      end
      if (ready) break;
      if (cyc > 100) begin check("wr_timeout", 1, 0); break; end
      check("wr_awvalid", awvalid, !aw_hs);
      check("wr_wvalid", wvalid, !w_hs);
      check("wr_bready", bready, aw_hs && w_hs && !b_hs);
      check("wr_no_ar", arvalid, 0);
      if (awvalid) begin
        if (aw_cnt >= aw_dly) begin
          awready = 1; aw_hs = 1; cap_addr = awaddr;
          check("awaddr", awaddr, e_addr);
          check("aw_const", {awid, awlen, awsize, awburst, awlock, awcache, awprot, awqos}, AXI_CONST);
        end
        aw_cnt++;
      end
      if (wvalid) begin
        if (w_cnt >= w_dly) begin
          wready = 1; w_hs = 1; cap_data = wdata; cap_strb = wstrb;
          check("wstrb", wstrb, e_strb);
          check("wdata", wdata, e_data);
          check("wlast", wlast, 1);
        end
        w_cnt++;
      end
      if (bready) begin
        if (b_cnt >= b_dly) begin
          bvalid = 1; b_hs = 1; bid = 4'($urandom); bresp = 2'($urandom);
          for (int i = 0; i < 4; i++)
            if (cap_strb[i]) smem[cap_addr[7:2]][8*i +: 8] = cap_data[8*i +: 8];
        end
        b_cnt++;
      end
    end
    check("wr_latency", cyc, 3 + mx + b_dly);
    check("wr_load_hold", load, last_load);
    write = 0; done = 1;
    @(negedge clk);
    check("wr_ready_once", ready, 0);
    done = 0;
  endtask

  task automatic do_read(input logic [7:0] a, input int ar_dly, input int r_dly,
                         input logic use_done, input logic with_write);
    logic [31:0] e_addr, e_load, cap_addr;
    logic        ar_hs, r_hs;
    int          ar_cnt, r_cnt, cyc;
    e_addr = {24'h0, a[7:2], 2'b00};
    e_load = {mb[e_addr[7:0] + 8'd3], mb[e_addr[7:0] + 8'd2], mb[e_addr[7:0] + 8'd1], mb[e_addr[7:0]]};
    ar_hs = 0; r_hs = 0; ar_cnt = 0; r_cnt = 0; cyc = 0; cap_addr = 0;
    @(negedge clk);
    read = 1; write = with_write ? 2'b11 : 2'b00; addr = {24'h0, a}; store = $urandom; done = 0;
    while (1) begin
      @(negedge clk);
      cyc++;
      arready = 0; rvalid = 0; rlast = 0;
      if (cyc == 1) addr = $urandom;
      if (ready) break;
      if (cyc > 100) begin check("rd_timeout", 1, 0); break; end
      check("rd_arvalid", arvalid, !ar_hs);
      check("rd_rready", rready, ar_hs && !r_hs);
      check("rd_no_aw", {awvalid, wvalid}, 0);
      if (arvalid) begin
        if (ar_cnt >= ar_dly) begin
          arready = 1; ar_hs = 1; cap_addr = araddr;
          check("araddr", araddr, e_addr);
          check("ar_const", {arid, arlen, arsize, arburst, arlock, arcache, arprot, arqos}, AXI_CONST);
        end
        ar_cnt++;
      end
      if (rready) begin
        if (r_cnt >= r_dly) begin
          rvalid = 1; rlast = 1; r_hs = 1;
          rdata = smem[cap_addr[7:2]]; rresp = 2'($urandom); rid = 4'($urandom);
        end
        r_cnt++;
      end
    end
    check("rd_latency", cyc, 3 + ar_dly + r_dly);
    check("rd_load", load, e_load);
    last_load = e_load;
    read = 0; write = 0; done = use_done;
    @(negedge clk);
    check("rd_ready_once", ready, 0);
    done = 0;
    if (!use_done) begin
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        check("rd_no_reissue", {arvalid, ready}, 0);
        check("rd_load_stable", load, last_load);
      end
    end
  endtask

  task automatic reset_mid_read(input logic [7:0] a);
    int cyc;
    cyc = 0;
    @(negedge clk);
    read = 1; write = 0; addr = {24'h0, a}; done = 0; arready = 0;
    while (!arvalid && cyc < 20) begin @(negedge clk); cyc++; end
    check("rst_arvalid_seen", arvalid, 1);
    #2 nrst = 0;
    #1;
    check("rst_async_valids", {arvalid, rready, ready, awvalid, wvalid, bready}, 0);
    check("rst_async_load", load, 0);
    @(negedge clk);
    nrst = 1; read = 0;
    @(negedge clk);
    check("rst_idle", {arvalid, rready, ready, awvalid, wvalid, bready}, 0);
    last_load = 0;
  endtask

  initial begin
    logic [7:0] ra;
    logic [1:0] rs;
    nrst = 0; read = 0; write = 0; addr = 0; store = 0; done = 0;
    awready = 0; wready = 0; bvalid = 0; bid = 0; bresp = 0;
    arready = 0; rvalid = 0; rid = 0; rdata = 0; rresp = 0; rlast = 0;
    for (int i = 0; i < 256; i++) mb[i] = 8'h00;
    for (int i = 0; i < 64; i++) smem[i] = 32'h0;
    last_load = 0;
    #12;
    check("reset_valids", {awvalid, wvalid, arvalid, bready, rready, ready}, 0);
    check("reset_load", load, 0);
    @(negedge clk);
    nrst = 1;

    // directed cases
    do_write(2'b11, 8'h20, 32'h0000_0000, 0, 0, 0);
    do_read(8'h20, 0, 0, 1'b1, 1'b0);
    do_write(2'b10, 8'h20, 32'hABCD_1234, 0, 0, 0);
    do_read(8'h20, 1, 2, 1'b1, 1'b0);
    check("half_readback", last_load, 32'h0000_1234);
    do_write(2'b01, 8'h23, 32'h0000_005A, 0, 0, 1);
    do_read(8'h20, 0, 0, 1'b1, 1'b0);
    check("byte_readback", last_load, 32'h5A00_1234);
    do_write(2'b11, 8'h24, 32'hDEAD_BEEF, 5, 0, 0);   // AW stalled, W first
    do_write(2'b11, 8'h28, 32'h1357_9BDF, 0, 4, 2);   // W stalled, AW first
    do_read(8'h24, 0, 0, 1'b0, 1'b0);                 // drop request, no done
    check("stall_readback", last_load, 32'hDEAD_BEEF);
    do_read(8'h28, 2, 0, 1'b1, 1'b1);                 // read wins over write

    // randomized traffic
    for (int n = 0; n < 60; n++) begin
      ra = 8'($urandom_range(0, 63));
      if ($urandom_range(0, 1) == 0) begin
        rs = 2'($urandom_range(1, 3));
        if (rs == 2'b10) ra[0] = 1'b0;
        if (rs == 2'b11) ra[1:0] = 2'b00;
        do_write(rs, ra, $urandom, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      end else begin
        do_read(ra, $urandom_range(0, 3), $urandom_range(0, 3),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
    end

    reset_mid_read(8'h24);
    do_read(8'h24, 0, 0, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
